// File: rtl/zeroheti_apb_mtimer.sv
// zeroheti_apb_mtimer: RISC-V machine timer (64-bit mtime, prescaler, mtimecmp) on an APB4 subordinate port
module zeroheti_apb_mtimer #(
  parameter int PRESC_WIDTH = 8,
  parameter bit IRQ_LATCHED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        timer_irq,
  output logic [63:0] mtime
);
  logic                   access, err, wr, rd, tick, cmp_hit, en, en_nxt, irq_nxt, unused;
  logic [2:0]             idx;
  logic [31:0]            hi_shadow, ctrl_r, ctrl_w;
  logic [63:0]            cmp, mtime_nxt, cmp_nxt;
  logic [PRESC_WIDTH-1:0] presc, presc_cnt, presc_nxt, cnt_nxt;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int i = 0; i < 4; i++) merge[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
  endfunction

  assign access  = psel & penable;
  assign err     = access & ((paddr[4:0] > 5'h10) | (paddr[1:0] != 2'b00));
  assign wr      = access & ~err & pwrite;
  assign rd      = access & ~err & ~pwrite;
  assign idx     = paddr[4:2];
  assign pready  = 1'b1;
  assign pslverr = err;
  assign ctrl_r  = 32'({presc, 7'b0, en});
  assign ctrl_w  = merge(ctrl_r, pwdata, pstrb);
  assign tick    = en & (presc_cnt == presc);
  assign cmp_hit = mtime >= cmp;
  assign unused  = ^{paddr[31:5], ctrl_w};

  // Read mux: only a valid ACCESS-phase read drives data, everything else reads zero
  always_comb begin
    prdata = !rd           ? 32'h0 :
             idx == 3'd0   ? mtime[31:0] :
             idx == 3'd1   ? hi_shadow :
             idx == 3'd2   ? cmp[31:0] :
             idx == 3'd3   ? cmp[63:32] : ctrl_r;
  end

  // Next-state: bus writes take priority over counting; a timer write restarts the prescaler
  always_comb begin
    mtime_nxt = (wr && idx == 3'd0) ? {mtime[63:32], merge(mtime[31:0], pwdata, pstrb)} :
                (wr && idx == 3'd1) ? {merge(mtime[63:32], pwdata, pstrb), mtime[31:0]} :
                tick                ? mtime + 64'd1 : mtime;
    cmp_nxt   = (wr && idx == 3'd2) ? {cmp[63:32], merge(cmp[31:0], pwdata, pstrb)} :
                (wr && idx == 3'd3) ? {merge(cmp[63:32], pwdata, pstrb), cmp[31:0]} : cmp;
    cnt_nxt   = (wr && (idx == 3'd0 || idx == 3'd1 || idx == 3'd4)) ? '0 :
                tick ? '0 : en ? presc_cnt + PRESC_WIDTH'(1) : presc_cnt;
    en_nxt    = (wr && idx == 3'd4) ? ctrl_w[0] : en;
    presc_nxt = (wr && idx == 3'd4) ? ctrl_w[8 +: PRESC_WIDTH] : presc;
    irq_nxt   = IRQ_LATCHED ? ((wr && idx <= 3'd3) ? 1'b0 : (cmp_hit | timer_irq)) : cmp_hit;
  end

  // State registers, asynchronously cleared; LO reads snapshot the upper word for tear-free HI reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime     <= '0;
      cmp       <= '1;
      en        <= 1'b0;
      presc     <= '0;
      presc_cnt <= '0;
      hi_shadow <= '0;
      timer_irq <= 1'b0;
    end else begin
      mtime     <= mtime_nxt;
      cmp       <= cmp_nxt;
      en        <= en_nxt;
      presc     <= presc_nxt;
      presc_cnt <= cnt_nxt;
      hi_shadow <= (rd && idx == 3'd0) ? mtime[63:32] : hi_shadow;
      timer_irq <= irq_nxt;
    end
  end
endmodule

// File: tb/tb_zeroheti_apb_mtimer.sv
// tb_zeroheti_apb_mtimer: scoreboard-driven bench for the APB machine timer
module tb_zeroheti_apb_mtimer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, timer_irq;
  logic [63:0] mtime;

  typedef struct {logic [31:0] d; logic e; string t;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int n_chk = 0, n_fail = 0;

  zeroheti_apb_mtimer dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .timer_irq(timer_irq), .mtime(mtime)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd(input string t, input logic [31:0] a, input logic [31:0] exp, input logic e);
    sb.push_back('{d: exp, e: e, t: t});
    apb(1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic wr(input string t, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic e);
    sb.push_back('{d: 32'h0, e: e, t: t});
    apb(1'b1, a, d, s);
  endtask

  // Each completed ACCESS phase consumes one expected response
  always @(negedge clk) begin
    if (rst_n && psel && penable) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: got unexpected access at %h expected none", paddr);
      end else begin
        mon_e = sb.pop_front();
        if (!pwrite) chk({mon_e.t, "_prdata"}, 64'(prdata), 64'(mon_e.d));
        chk({mon_e.t, "_pslverr"}, 64'(pslverr), 64'(mon_e.e));
        chk({mon_e.t, "_pready"}, 64'(pready), 64'd1);
      end
    end
  end

  initial begin
    cyc(3);
    rst_n = 1'b1;
    chk("rst_mtime", mtime, 64'h0);
    chk("rst_irq", 64'(timer_irq), 64'h0);
    // reset values through the bus
    rd("t1_mlo", 32'h00, 32'h0, 1'b0);
    rd("t1_mhi", 32'h04, 32'h0, 1'b0);
    rd("t1_clo", 32'h08, 32'hFFFF_FFFF, 1'b0);
    rd("t1_chi", 32'h0C, 32'hFFFF_FFFF, 1'b0);
    rd("t1_ctrl", 32'h10, 32'h0, 1'b0);
    // prescaler 3: one tick per 4 cycles
    wr("t2_ctrl", 32'h10, 32'h0000_0301, 4'hF, 1'b0);
    cyc(40);
    chk("t2_mtime40", mtime, 64'd10);
    wr("t2_off", 32'h10, 32'h0, 4'hF, 1'b0);
    cyc(8);
    chk("t2_hold", mtime, 64'd10);
    // LO/HI snapshot across the 32-bit carry
    wr("t3_mlo", 32'h00, 32'hFFFF_FFFD, 4'hF, 1'b0);
    wr("t3_ctrl", 32'h10, 32'h1, 4'hF, 1'b0);
    rd("t3_lo", 32'h00, 32'hFFFF_FFFF, 1'b0);
    rd("t3_hi", 32'h04, 32'h0, 1'b0);
    chk("t3_carry", mtime, 64'h1_0000_0003);
    wr("t3_off", 32'h10, 32'h0, 4'hF, 1'b0);
    chk("t3_stop", mtime, 64'h1_0000_0006);
    // compare and interrupt
    wr("t4_mhi", 32'h04, 32'h0, 4'hF, 1'b0);
    wr("t4_mlo", 32'h00, 32'h1C, 4'hF, 1'b0);
    wr("t4_clo", 32'h08, 32'h20, 4'hF, 1'b0);
    wr("t4_chi", 32'h0C, 32'h0, 4'hF, 1'b0);
    chk("t4_irq_idle", 64'(timer_irq), 64'h0);
    wr("t4_ctrl", 32'h10, 32'h1, 4'hF, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      chk($sformatf("t4_irq_c%0d", k), 64'(timer_irq), 64'(k == 5));
    end
    wr("t4_clo2", 32'h08, 32'h100, 4'hF, 1'b0);
    cyc(1);
    chk("t4_irq_fall", 64'(timer_irq), 64'h0);
    chk("t4_mtime", mtime, 64'h25);
    wr("t4_off", 32'h10, 32'h0, 4'hF, 1'b0);
    // byte write racing an increment, then prescaler restart
    wr("t5_mlo", 32'h00, 32'h1234_5678, 4'hF, 1'b0);
    wr("t5_mhi", 32'h04, 32'hA5A5_A5A5, 4'hF, 1'b0);
    wr("t5_ctrl", 32'h10, 32'h1, 4'hF, 1'b0);
    wr("t5_b0", 32'h00, 32'h0000_0055, 4'b0001, 1'b0);
    chk("t5_wins", mtime, 64'hA5A5_A5A5_1234_5655);
    cyc(1);
    chk("t5_next", mtime, 64'hA5A5_A5A5_1234_5656);
    wr("t5_ctrl3", 32'h10, 32'h0000_0301, 4'hF, 1'b0);
    wr("t5_b0b", 32'h00, 32'hFFFF_FF55, 4'b0001, 1'b0);
    chk("t5_wr2", mtime, 64'hA5A5_A5A5_1234_5655);
    cyc(3);
    chk("t5_restart_hold", mtime, 64'hA5A5_A5A5_1234_5655);
    cyc(1);
    chk("t5_restart_tick", mtime, 64'hA5A5_A5A5_1234_5656);
    // error responses leave state untouched; upper address bits ignored
    rd("t6_rd14", 32'h14, 32'h0, 1'b1);
    rd("t6_rd02", 32'h02, 32'h0, 1'b1);
    wr("t6_wr14", 32'h14, 32'hFFFF_FFFF, 4'hF, 1'b1);
    wr("t6_wr0a", 32'h0A, 32'hDEAD_BEEF, 4'hF, 1'b1);
    rd("t6_chi", 32'h0C, 32'h0, 1'b0);
    rd("t6_clo", 32'h08, 32'h100, 1'b0);
    rd("t6_ctrl_alias", 32'hFFFF_FF10, 32'h301, 1'b0);
    chk("t6_irq_pre", 64'(timer_irq), 64'h1);
    // asynchronous reset mid-count
    rst_n = 1'b0;
    #2;
    chk("t6_rst_mtime", mtime, 64'h0);
    chk("t6_rst_irq", 64'(timer_irq), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("t6_ctrl_rst", 32'h10, 32'h0, 1'b0);
    rd("t6_chi_rst", 32'h0C, 32'hFFFF_FFFF, 1'b0);
    rd("t6_mlo_rst", 32'h00, 32'h0, 1'b0);
    cyc(2);
    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
